// File: rtl/nerv_dmem_bridge_pkg.sv
// Shared types for the NERV data-memory bridge: FSM state encoding and strobe decode helper.
package nerv_dmem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACK,
        RDATA
    } dmem_bridge_state_t;

    function automatic logic isReadStrobe(input logic [3:0] wstrb);
        return (wstrb == 4'b0000);
    endfunction

endpackage

// File: rtl/nerv_dmem_bridge_if.sv
// Valid/ready system bus between the bridge (master) and the memory system (slave).
interface nerv_dmem_bridge_if;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_error;

    modport master (
        output bus_req_valid,
        input  bus_req_ready,
        output bus_req_addr,
        output bus_req_wstrb,
        output bus_req_wdata,
        input  bus_rsp_valid,
        input  bus_rsp_rdata,
        input  bus_rsp_error
    );

    modport slave (
        input  bus_req_valid,
        output bus_req_ready,
        input  bus_req_addr,
        input  bus_req_wstrb,
        input  bus_req_wdata,
        output bus_rsp_valid,
        output bus_rsp_rdata,
        output bus_rsp_error
    );

endinterface

// File: rtl/nerv_dmem_bridge.sv
// Bridges the NERV core data port onto a variable-latency valid/ready bus, stalling the core
// while a transaction is in flight and replaying load data in the core's writeback cycle.
module nerv_dmem_bridge
    import nerv_dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      stall_in,
    output logic                      stall,
    input  logic                      dmem_valid,
    input  logic [31:0]               dmem_addr,
    input  logic [3:0]                dmem_wstrb,
    input  logic [31:0]               dmem_wdata,
    output logic [31:0]               dmem_rdata,
    nerv_dmem_bridge_if.master        bus,
    output logic                      bus_fault
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    dmem_bridge_state_t r_state;
    dmem_bridge_state_t w_nextState;

    logic [31:0]      r_addr;
    logic [3:0]       r_wstrb;
    logic [31:0]      r_wdata;
    logic             r_isRead;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_count;
    logic             r_fault;
    logic             w_timeout;

    assign w_timeout = TIMEOUT_EN && (r_count == CNT_LAST);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The resetn term keeps a held dmem_valid from stalling the core while the bridge is in reset.
    always_comb begin
        w_nextState       = r_state;
        stall             = stall_in;
        bus.bus_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (dmem_valid && resetn) begin
                    stall = 1'b1;
                end
                if (dmem_valid) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                stall             = 1'b1;
                bus.bus_req_valid = 1'b1;
                if (bus.bus_req_ready) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.bus_rsp_valid || w_timeout) begin
                    w_nextState = ACK;
                end
            end
            ACK: begin
                if (!stall_in) begin
                    w_nextState = r_isRead ? RDATA : IDLE;
                end
            end
            RDATA: begin
                if (!stall_in) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A response arriving on the final timeout cycle wins over the timeout.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_addr   <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            r_isRead <= 1'b0;
            r_rdata  <= '0;
            r_count  <= '0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dmem_valid) begin
                        r_addr   <= dmem_addr;
                        r_wstrb  <= dmem_wstrb;
                        r_wdata  <= dmem_wdata;
                        r_isRead <= isReadStrobe(dmem_wstrb);
                    end
                end
                REQ: begin
                    if (bus.bus_req_ready) begin
                        r_count <= '0;
                    end
                end
                WAIT: begin
                    if (bus.bus_rsp_valid) begin
                        r_rdata <= bus.bus_rsp_error ? 32'h0 : bus.bus_rsp_rdata;
                        r_fault <= r_fault | bus.bus_rsp_error;
                    end else if (w_timeout) begin
                        r_rdata <= 32'h0;
                        r_fault <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bus_req_addr  = r_addr;
    assign bus.bus_req_wstrb = r_wstrb;
    assign bus.bus_req_wdata = r_wdata;
    assign dmem_rdata        = r_rdata;
    assign bus_fault         = r_fault;

endmodule

// File: tb/tb_nerv_dmem_bridge.sv
// Directed bench for nerv_dmem_bridge: table of single accesses plus scripted corner-case sequences.
module tb_nerv_dmem_bridge;

    logic        clock;
    logic        resetn;
    logic        stallIn;
    logic        stall;
    logic        dmemValid;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemWstrb;
    logic [31:0] dmemWdata;
    logic [31:0] dmemRdata;
    logic        busFault;

    int checks = 0;
    int errors = 0;
    int hsCount = 0;

    nerv_dmem_bridge_if bif();

    nerv_dmem_bridge #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .stall_in   (stallIn),
        .stall      (stall),
        .dmem_valid (dmemValid),
        .dmem_addr  (dmemAddr),
        .dmem_wstrb (dmemWstrb),
        .dmem_wdata (dmemWdata),
        .dmem_rdata (dmemRdata),
        .bus        (bif),
        .bus_fault  (busFault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bif.bus_req_valid && bif.bus_req_ready) hsCount++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          readyDelay;
        int          rspDelay;
        logic [31:0] rspData;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic issueIdle(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
        dmemValid = 1'b1;
        dmemAddr = addr;
        dmemWstrb = wstrb;
        dmemWdata = wdata;
        bif.bus_req_ready = 1'b0;
        bif.bus_rsp_valid = 1'b0;
        #2;
        checkOutput("idleStall", 32'(stall), 32'd1);
        checkOutput("idleReqValid", 32'(bif.bus_req_valid), 32'd0);
        step();
    endtask

    task automatic reqPhase(input int delay, input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata);
        for (int d = 0; d <= delay; d++) begin
            bif.bus_req_ready = (d == delay);
            #2;
            checkOutput("reqValid", 32'(bif.bus_req_valid), 32'd1);
            checkOutput("reqAddr", bif.bus_req_addr, addr);
            checkOutput("reqWstrb", 32'(bif.bus_req_wstrb), 32'(wstrb));
            checkOutput("reqWdata", bif.bus_req_wdata, wdata);
            checkOutput("reqStall", 32'(stall), 32'd1);
            step();
        end
        bif.bus_req_ready = 1'b0;
    endtask

    task automatic waitPhase(input int delay, input logic [31:0] data, input logic err);
        for (int w = 0; w <= delay; w++) begin
            bif.bus_rsp_valid = (w == delay);
            bif.bus_rsp_rdata = data;
            bif.bus_rsp_error = (w == delay) ? err : 1'b0;
            #2;
            checkOutput("waitStall", 32'(stall), 32'd1);
            checkOutput("waitReqValid", 32'(bif.bus_req_valid), 32'd0);
            step();
        end
        bif.bus_rsp_valid = 1'b0;
        bif.bus_rsp_error = 1'b0;
        bif.bus_rsp_rdata = ~data;
    endtask

    task automatic finishAck(input logic [31:0] expRdata, input logic isRead, input logic expFault);
        dmemValid = 1'b0;
        stallIn = 1'b0;
        #2;
        checkOutput("ackStall", 32'(stall), 32'd0);
        checkOutput("ackRdata", dmemRdata, expRdata);
        checkOutput("ackFault", 32'(busFault), 32'(expFault));
        checkOutput("ackReqValid", 32'(bif.bus_req_valid), 32'd0);
        step();
        if (isRead) begin
            #2;
            checkOutput("rdataStall", 32'(stall), 32'd0);
            checkOutput("rdataValue", dmemRdata, expRdata);
            step();
        end
    endtask

    // One full access; the following idle check of the next access proves the return to IDLE.
    task automatic applyStimulus(input vec_t v, input logic expFault);
        int hs0;
        hs0 = hsCount;
        issueIdle(v.addr, v.wstrb, v.wdata);
        reqPhase(v.readyDelay, v.addr, v.wstrb, v.wdata);
        waitPhase(v.rspDelay, v.rspData, 1'b0);
        finishAck(v.expRdata, (v.wstrb == 4'b0000), expFault);
        checkOutput("handshakes", 32'(hsCount - hs0), 32'd1);
    endtask

    initial begin
        int hs0;
        vec_t stickyVec;

        vecs[0] = '{32'h0000_0100, 4'b0000, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0204, 4'b0011, 32'h0000_ABCD, 3, 0, 32'h1111_1111, 32'h1111_1111};
        vecs[2] = '{32'h0000_03FC, 4'b0000, 32'h0000_0000, 1, 2, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 0, 1, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'h0000_0000, 4'b0000, 32'h0000_0000, 2, 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        stickyVec = '{32'h0000_0700, 4'b0000, 32'h0000_0000, 0, 0, 32'h0000_1234, 32'h0000_1234};

        resetn = 1'b0;
        stallIn = 1'b0;
        dmemValid = 1'b1;
        dmemAddr = '0;
        dmemWstrb = '0;
        dmemWdata = '0;
        bif.bus_req_ready = 1'b0;
        bif.bus_rsp_valid = 1'b0;
        bif.bus_rsp_rdata = '0;
        bif.bus_rsp_error = 1'b0;
        step();
        step();
        #2;
        checkOutput("rstStall", 32'(stall), 32'd0);
        checkOutput("rstReqValid", 32'(bif.bus_req_valid), 32'd0);
        checkOutput("rstFault", 32'(busFault), 32'd0);
        checkOutput("rstRdata", dmemRdata, 32'h0);
        resetn = 1'b1;
        dmemValid = 1'b0;
        #1;
        checkOutput("idleNoValidStall", 32'(stall), 32'd0);
        stallIn = 1'b1;
        #1;
        checkOutput("idleStallIn", 32'(stall), 32'd1);
        stallIn = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], 1'b0);
        end

        $display("[TB] back-to-back load then store");
        hs0 = hsCount;
        issueIdle(32'h40, 4'b0000, 32'h0);
        reqPhase(0, 32'h40, 4'b0000, 32'h0);
        waitPhase(0, 32'h0000_0055, 1'b0);
        dmemValid = 1'b1;
        dmemAddr = 32'h44;
        dmemWstrb = 4'b1111;
        dmemWdata = 32'h99;
        #2;
        checkOutput("b2bAckStall", 32'(stall), 32'd0);
        checkOutput("b2bAckRdata", dmemRdata, 32'h55);
        step();
        #2;
        checkOutput("b2bRdataStall", 32'(stall), 32'd0);
        checkOutput("b2bRdataReqValid", 32'(bif.bus_req_valid), 32'd0);
        checkOutput("b2bRdataValue", dmemRdata, 32'h55);
        step();
        issueIdle(32'h44, 4'b1111, 32'h99);
        reqPhase(0, 32'h44, 4'b1111, 32'h99);
        waitPhase(0, 32'h0, 1'b0);
        finishAck(32'h0, 1'b0, 1'b0);
        checkOutput("b2bHandshakes", 32'(hsCount - hs0), 32'd2);

        $display("[TB] stall_in during ACK and RDATA");
        issueIdle(32'h80, 4'b0000, 32'h0);
        reqPhase(0, 32'h80, 4'b0000, 32'h0);
        waitPhase(0, 32'h0000_0077, 1'b0);
        bif.bus_rsp_rdata = 32'h0000_0BAD;
        stallIn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            checkOutput("ackHeldStall", 32'(stall), 32'd1);
            checkOutput("ackHeldReqValid", 32'(bif.bus_req_valid), 32'd0);
            checkOutput("ackHeldRdata", dmemRdata, 32'h77);
            step();
        end
        stallIn = 1'b0;
        #2;
        checkOutput("ackReleaseStall", 32'(stall), 32'd0);
        step();
        stallIn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            checkOutput("rdataHeldStall", 32'(stall), 32'd1);
            checkOutput("rdataHeldReqValid", 32'(bif.bus_req_valid), 32'd0);
            checkOutput("rdataHeldRdata", dmemRdata, 32'h77);
            step();
        end
        stallIn = 1'b0;
        dmemValid = 1'b0;
        #2;
        checkOutput("rdataReleaseStall", 32'(stall), 32'd0);
        checkOutput("rdataReleaseRdata", dmemRdata, 32'h77);
        step();

        $display("[TB] response timeout");
        issueIdle(32'h300, 4'b0000, 32'h0);
        reqPhase(0, 32'h300, 4'b0000, 32'h0);
        for (int w = 0; w < 4; w++) begin
            #2;
            checkOutput("toWaitStall", 32'(stall), 32'd1);
            checkOutput("toWaitFault", 32'(busFault), 32'd0);
            step();
        end
        finishAck(32'h0, 1'b1, 1'b1);

        applyStimulus(stickyVec, 1'b1);

        $display("[TB] reset during WAIT");
        issueIdle(32'h600, 4'b0000, 32'h0);
        reqPhase(0, 32'h600, 4'b0000, 32'h0);
        resetn = 1'b0;
        #2;
        checkOutput("waitRstStall", 32'(stall), 32'd1);
        step();
        resetn = 1'b1;
        dmemValid = 1'b0;
        stallIn = 1'b1;
        #2;
        checkOutput("postRstReqValid", 32'(bif.bus_req_valid), 32'd0);
        checkOutput("postRstFault", 32'(busFault), 32'd0);
        checkOutput("postRstRdata", dmemRdata, 32'h0);
        checkOutput("postRstStallHi", 32'(stall), 32'd1);
        stallIn = 1'b0;
        #1;
        checkOutput("postRstStallLo", 32'(stall), 32'd0);
        step();

        $display("[TB] error response");
        issueIdle(32'h500, 4'b0000, 32'h0);
        reqPhase(1, 32'h500, 4'b0000, 32'h0);
        waitPhase(1, 32'hFFFF_FFFF, 1'b1);
        finishAck(32'h0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
